// File: rtl/run_sequencer.sv
// Session sequencer for a small core: streams a program/data image into memory,
// releases the core until done or timeout, then streams a memory window back out.
module run_sequencer #(
  parameter logic [7:0] LOAD_BASE = 8'h00,
  parameter logic [7:0] DUMP_BASE = 8'h00,
  parameter int         DUMP_LEN  = 16,
  parameter int         TIMEOUT   = 4095
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  load_len,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        cpu_reset,
  input  logic        cpu_done,
  output logic        mem_wr_en,
  output logic [7:0]  mem_addr,
  output logic [7:0]  mem_wr_data,
  input  logic [7:0]  mem_rd_data,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic        busy,
  output logic        timeout,
  output logic [15:0] cycles
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DUMP
  } state_t;

  localparam logic [7:0]  DUMP_LAST   = 8'(DUMP_LEN - 1);
  localparam logic [15:0] TIMEOUT_VAL = 16'(TIMEOUT);

  state_t      state_reg, state_next;
  logic [7:0]  idx_reg, idx_next;
  logic [7:0]  load_len_reg, load_len_next;
  logic [15:0] cycles_reg, cycles_next;
  logic        timeout_reg, timeout_next;
  logic [15:0] cycles_inc;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= S_IDLE;
      idx_reg      <= 8'd0;
      load_len_reg <= 8'd0;
      cycles_reg   <= 16'd0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      load_len_reg <= load_len_next;
      cycles_reg   <= cycles_next;
      timeout_reg  <= timeout_next;
    end
  end

  // Saturating count; the value after this RUN edge is what the timeout compares against.
  assign cycles_inc = (cycles_reg == 16'hFFFF) ? cycles_reg : cycles_reg + 16'd1;

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    load_len_next = load_len_reg;
    cycles_next   = cycles_reg;
    timeout_next  = timeout_reg;
    busy          = 1'b0;
    in_ready      = 1'b0;
    cpu_reset     = 1'b1;
    mem_wr_en     = 1'b0;
    mem_addr      = 8'd0;
    mem_wr_data   = 8'd0;
    out_valid     = 1'b0;
    out_data      = 8'd0;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          load_len_next = load_len;
          idx_next      = 8'd0;
          cycles_next   = 16'd0;
          timeout_next  = 1'b0;
          state_next    = (load_len == 8'd0) ? S_RUN : S_LOAD;
        end
      end

      S_LOAD: begin
        busy        = 1'b1;
        in_ready    = 1'b1;
        mem_addr    = LOAD_BASE + idx_reg;
        mem_wr_data = in_data;
        if (in_valid) begin
          mem_wr_en = 1'b1;
          if (idx_reg == load_len_reg - 8'd1) begin
            idx_next   = 8'd0;
            state_next = S_RUN;
          end else begin
            idx_next = idx_reg + 8'd1;
          end
        end
      end

      S_RUN: begin
        busy        = 1'b1;
        cpu_reset   = 1'b0;
        cycles_next = cycles_inc;
        // Done takes priority over a timeout landing on the same edge.
        if (cpu_done) begin
          idx_next   = 8'd0;
          state_next = S_DUMP;
        end else if (cycles_inc == TIMEOUT_VAL) begin
          idx_next     = 8'd0;
          timeout_next = 1'b1;
          state_next   = S_DUMP;
        end
      end

      S_DUMP: begin
        busy      = 1'b1;
        mem_addr  = DUMP_BASE + idx_reg;
        out_valid = 1'b1;
        out_data  = mem_rd_data;
        if (out_ready) begin
          if (idx_reg == DUMP_LAST) begin
            idx_next   = 8'd0;
            state_next = S_IDLE;
          end else begin
            idx_next = idx_reg + 8'd1;
          end
        end
      end

      default: state_next = S_IDLE;
    endcase
  end

  assign timeout = timeout_reg;
  assign cycles  = cycles_reg;

endmodule
